except_unit: RTL



---
 rtl/except_unit.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/except_unit.sv
// Exception and interrupt arbitration ahead of cp0.
// Emits a one-cycle registered request plus the redirect target.

package except_pkg;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_CPU  = 5'd11;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;
    localparam logic [4:0] EXCCODE_TR   = 5'd13;

    typedef struct packed {
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] count;
        logic [31:0] compare;
        logic [31:0] epc;
        logic [31:0] error_epc;
        logic [31:0] ebase;
    } CP0Regs_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [2:0]  sel;
        logic [31:0] wdata;
    } CP0RegWriteReq_t;

    typedef struct packed {
        logic        flush;
        logic        eret;
        logic [4:0]  code;
        logic [31:0] extra;
        logic [31:0] cur_pc;
        logic        delayslot;
    } ExceptReq_t;

endpackage

module except_unit
    import except_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      hw_int,
    input  logic            mem_valid,
    input  logic [31:0]     mem_pc,
    input  logic            mem_delayslot,
    input  logic [31:0]     mem_addr,
    input  logic [11:0]     mem_flags,
    input  logic            mem_mod,
    input  logic            mem_refill,
    input  logic [1:0]      mem_cpu_num,
    input  logic            mem_eret,
    input  CP0Regs_t        cp0_regs,
    input  CP0RegWriteReq_t cp0_wr,
    output ExceptReq_t      except_req,
    output logic [31:0]     redirect_pc,
    output logic            timer_int
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t state;

    logic [5:0] hw_m;
    logic [5:0] hw_s;

    logic       st_ie;
    logic       st_exl;
    logic       st_erl;
    logic       st_bev;
    logic [7:0] st_im;

    assign st_ie  = cp0_regs.status[0];
    assign st_exl = cp0_regs.status[1];
    assign st_erl = cp0_regs.status[2];
    assign st_im  = cp0_regs.status[15:8];
    assign st_bev = cp0_regs.status[22];

    logic f_if_adel, f_if_tlbl, f_ri, f_cpu;
    logic f_ov, f_sys, f_bp, f_tr;
    logic f_adel, f_ades, f_tlbl, f_tlbs;

    assign {f_if_adel, f_if_tlbl, f_ri, f_cpu,
            f_ov, f_sys, f_bp, f_tr,
            f_adel, f_ades, f_tlbl, f_tlbs} = mem_flags;

    logic [7:0] ip;
    logic       int_take;

    assign ip = {hw_s[5] | timer_int, hw_s[4:0],
                 cp0_regs.cause[9:8]};

    assign int_take = (|(ip & st_im)) & st_ie
                    & ~st_exl & ~st_erl;

    logic        cmp_wr;
    logic        cmp_hit;

    assign cmp_wr  = cp0_wr.we && cp0_wr.waddr == 5'd11
                  && cp0_wr.sel == 3'd0;
    assign cmp_hit = cp0_regs.count == cp0_regs.compare
                  && cp0_regs.compare != 32'd0;

    logic        hit;
    logic        is_eret;
    logic [4:0]  code;
    logic [31:0] extra;

    // Resolve the highest-priority cause; earlier arms win.
    always_comb begin
        hit     = 1'b1;
        is_eret = 1'b0;
        code    = EXCCODE_INT;
        extra   = 32'd0;
        priority case (1'b1)
            int_take: begin
                code  = EXCCODE_INT;
                extra = {24'd0, ip};
            end
            f_if_adel: begin
                code  = EXCCODE_ADEL;
                extra = mem_pc;
            end
            f_if_tlbl: begin
                code  = EXCCODE_TLBL;
                extra = mem_pc;
            end
            f_ri:  code = EXCCODE_RI;
            f_cpu: begin
                code  = EXCCODE_CPU;
                extra = {30'd0, mem_cpu_num};
            end
            f_ov:  code = EXCCODE_OV;
            f_sys: code = EXCCODE_SYS;
            f_bp:  code = EXCCODE_BP;
            f_tr:  code = EXCCODE_TR;
            f_adel: begin
                code  = EXCCODE_ADEL;
                extra = mem_addr;
            end
            f_ades: begin
                code  = EXCCODE_ADES;
                extra = mem_addr;
            end
            f_tlbl: begin
                code  = EXCCODE_TLBL;
                extra = mem_addr;
            end
            f_tlbs: begin
                code  = EXCCODE_TLBS;
                extra = mem_addr;
            end
            mem_mod: begin
                code  = EXCCODE_MOD;
                extra = mem_addr;
            end
            mem_eret: is_eret = 1'b1;
            default:  hit = 1'b0;
        endcase
    end

    logic        refill_vec;
    logic [31:0] vec_base;
    logic [31:0] vec_pc;
    logic [31:0] target;

    assign refill_vec = (code == EXCCODE_TLBL || code == EXCCODE_TLBS)
                      && mem_refill && !st_exl && !is_eret;
    assign vec_base = st_bev ? 32'hBFC0_0200
                             : {cp0_regs.ebase[31:12], 12'd0};
    assign vec_pc   = vec_base + (refill_vec ? 32'd0 : 32'h180);
    assign target   = !is_eret ? vec_pc
                    : st_erl ? cp0_regs.error_epc : cp0_regs.epc;

    ExceptReq_t req_d;

    // Assemble the request that gets registered on detection.
    always_comb begin
        req_d           = '0;
        req_d.flush     = 1'b1;
        req_d.eret      = is_eret;
        req_d.code      = code;
        req_d.extra     = extra;
        req_d.cur_pc    = mem_pc;
        req_d.delayslot = mem_delayslot;
    end

    // Two-flop synchroniser for the external interrupt lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_m <= 6'd0;
            hw_s <= 6'd0;
        end else begin
            hw_m <= hw_int;
            hw_s <= hw_m;
        end
    end

    // Timer latch: a compare write beats a simultaneous match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_int <= 1'b0;
        end else if (cmp_wr) begin
            timer_int <= 1'b0;
        end else if (cmp_hit) begin
            timer_int <= 1'b1;
        end
    end

    // Request FSM; the FLUSH cycle blanks out the wrong-path slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            except_req  <= '0;
            redirect_pc <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_valid && hit) begin
                        state       <= FLUSH;
                        except_req  <= req_d;
                        redirect_pc <= target;
                    end else begin
                        except_req <= '0;
                    end
                end
                FLUSH: begin
                    state      <= IDLE;
                    except_req <= '0;
                end
                default: begin
                    state      <= IDLE;
                    except_req <= '0;
                end
            endcase
        end
    end

    logic unused;
    assign unused = ^{cp0_regs.status[31:23],
                      cp0_regs.status[21:16],
                      cp0_regs.status[7:3],
                      cp0_regs.cause[31:10],
                      cp0_regs.cause[7:0],
                      cp0_regs.ebase[11:0],
                      cp0_wr.wdata};

endmodule
